// File: rtl/porf_ce_gen.sv
// porf_ce_gen: processor clock-enable / divided-clock generator with a
// power-on, external and (optionally) watchdog reset sequencer.
// A free-running phase counter divides clk_sys by DIV; every output is
// registered. The sequencer walks PRE -> HOLD -> RUN on proc_ce ticks.
// Optional feature: define PORF_WDT_EN to build the RUN-state watchdog.
module porf_ce_gen #(
    parameter int DIV         = 10,
    parameter int PRE_CYCLES  = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int MEM_PHASE   = 5,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_ext_rst_req,
    input  logic       i_wdt_kick,
    output logic       o_proc_ce,
    output logic       o_proc_clk,
    output logic       o_mem_phase,
    output logic       o_proc_resetn,
    output logic [1:0] o_state,
    output logic [1:0] o_rst_cause
);

    localparam int PW      = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int CYC_MAX = (PRE_CYCLES > HOLD_CYCLES) ? PRE_CYCLES : HOLD_CYCLES;
    localparam int CW      = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);

    typedef enum logic [1:0] {
        ST_PRE  = 2'b00,
        ST_HOLD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
`ifdef PORF_WDT_EN
    localparam logic [1:0] CAUSE_WDT = 2'b10;
`endif

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          r_proc_ce;
    logic          r_proc_clk;
    logic          r_mem_phase;
    logic          r_proc_resetn;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cyc;
    logic [CW-1:0] w_cyc_nxt;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_nxt;

`ifdef PORF_WDT_EN
    localparam int WW = (WDT_CYCLES < 2) ? 1 : $clog2(WDT_CYCLES);
    logic [WW-1:0] r_wdt;
    logic [WW-1:0] w_wdt_nxt;
    logic          w_timeout;
`else
    // The kick strobe has no consumer when the watchdog is not built.
    logic          w_unused_kick;
    assign w_unused_kick = i_wdt_kick;
`endif

    // Phase counter wraps at DIV-1; outputs are decoded from the next phase
    // so the registered strobes line up with the phase register.
    always_comb begin
        if (r_phase == PW'(DIV - 1)) begin
            w_phase_nxt = '0;
        end else begin
            w_phase_nxt = r_phase + PW'(1);
        end
    end

    // Sequencer next-state: everything advances only on a proc_ce tick.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_cause_nxt = r_cause;
`ifdef PORF_WDT_EN
        w_wdt_nxt   = r_wdt;
        w_timeout   = 1'b0;
`endif
        if (r_proc_ce) begin
            case (r_state)
                ST_PRE: begin
                    if (i_ext_rst_req) begin
                        w_state_nxt = ST_HOLD;
                        w_cyc_nxt   = '0;
                        w_cause_nxt = CAUSE_EXT;
                    end else if (int'(r_cyc) + 1 >= PRE_CYCLES) begin
                        w_state_nxt = ST_HOLD;
                        w_cyc_nxt   = '0;
                    end else begin
                        w_cyc_nxt   = r_cyc + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (i_ext_rst_req) begin
                        // A fresh request restarts the full hold interval.
                        w_cyc_nxt   = '0;
                        w_cause_nxt = CAUSE_EXT;
                    end else if (int'(r_cyc) + 1 >= HOLD_CYCLES) begin
                        w_state_nxt = ST_RUN;
                        w_cyc_nxt   = '0;
                    end else begin
                        w_cyc_nxt   = r_cyc + CW'(1);
                    end
                end
                ST_RUN: begin
`ifdef PORF_WDT_EN
                    w_timeout = !i_wdt_kick && (r_wdt == WW'(WDT_CYCLES - 1));
                    w_wdt_nxt = i_wdt_kick ? '0 : r_wdt + WW'(1);
`endif
                    if (i_ext_rst_req) begin
                        // External request wins over a coincident timeout.
                        w_state_nxt = ST_HOLD;
                        w_cyc_nxt   = '0;
                        w_cause_nxt = CAUSE_EXT;
`ifdef PORF_WDT_EN
                        w_wdt_nxt   = '0;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_HOLD;
                        w_cyc_nxt   = '0;
                        w_cause_nxt = CAUSE_WDT;
                        w_wdt_nxt   = '0;
`endif
                    end
                end
                default: begin
                    w_state_nxt = ST_PRE;
                    w_cyc_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_reset) begin
            r_phase       <= '0;
            r_proc_ce     <= 1'b0;
            r_proc_clk    <= 1'b1;
            r_mem_phase   <= 1'b0;
            r_proc_resetn <= 1'b1;
            r_state       <= ST_PRE;
            r_cyc         <= '0;
            r_cause       <= CAUSE_POR;
`ifdef PORF_WDT_EN
            r_wdt         <= '0;
`endif
        end else begin
            r_phase       <= w_phase_nxt;
            r_proc_ce     <= (w_phase_nxt == PW'(DIV - 1));
            r_proc_clk    <= (w_phase_nxt < PW'(DIV / 2));
            r_mem_phase   <= (w_phase_nxt == PW'(MEM_PHASE));
            r_proc_resetn <= (w_state_nxt != ST_HOLD);
            r_state       <= w_state_nxt;
            r_cyc         <= w_cyc_nxt;
            r_cause       <= w_cause_nxt;
`ifdef PORF_WDT_EN
            r_wdt         <= w_wdt_nxt;
`endif
        end
    end

    assign o_proc_ce     = r_proc_ce;
    assign o_proc_clk    = r_proc_clk;
    assign o_mem_phase   = r_mem_phase;
    assign o_proc_resetn = r_proc_resetn;
    assign o_state       = r_state;
    assign o_rst_cause   = r_cause;

endmodule

// File: tb/tb_porf_ce_gen.sv
// tb_porf_ce_gen: directed bench for porf_ce_gen. Tick index t counts clk_sys
// edges since the last reset release; expected values are written in terms
// of t (phase = t mod DIV). Watchdog checks build when PORF_WDT_EN is defined.
module tb_porf_ce_gen;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset       = 1'b1;
    logic ext_rst_req = 1'b0;
    logic wdt_kick    = 1'b0;
    logic tie_zero    = 1'b0;

    logic       proc_ce, proc_clk, mem_phase, proc_resetn;
    logic [1:0] state, rst_cause;

    logic       d2_ce, d2_clk, d2_mem, d2_resetn;
    logic [1:0] d2_state, d2_cause;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;
    logic seen_wdt_cause = 1'b0;

    porf_ce_gen u_dut (
        .i_clk_sys     (clk_sys),
        .i_reset       (reset),
        .i_ext_rst_req (ext_rst_req),
        .i_wdt_kick    (wdt_kick),
        .o_proc_ce     (proc_ce),
        .o_proc_clk    (proc_clk),
        .o_mem_phase   (mem_phase),
        .o_proc_resetn (proc_resetn),
        .o_state       (state),
        .o_rst_cause   (rst_cause)
    );

    porf_ce_gen #(.DIV(2), .MEM_PHASE(1)) u_div2 (
        .i_clk_sys     (clk_sys),
        .i_reset       (reset),
        .i_ext_rst_req (tie_zero),
        .i_wdt_kick    (tie_zero),
        .o_proc_ce     (d2_ce),
        .o_proc_clk    (d2_clk),
        .o_mem_phase   (d2_mem),
        .o_proc_resetn (d2_resetn),
        .o_state       (d2_state),
        .o_rst_cause   (d2_cause)
    );

`ifdef PORF_WDT_EN
    logic       w_ce, w_clk, w_mem, w_resetn;
    logic [1:0] w_state, w_cause;

    porf_ce_gen #(.WDT_CYCLES(8)) u_wdt (
        .i_clk_sys     (clk_sys),
        .i_reset       (reset),
        .i_ext_rst_req (tie_zero),
        .i_wdt_kick    (wdt_kick),
        .o_proc_ce     (w_ce),
        .o_proc_clk    (w_clk),
        .o_mem_phase   (w_mem),
        .o_proc_resetn (w_resetn),
        .o_state       (w_state),
        .o_rst_cause   (w_cause)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (t=%0d): got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // One clk_sys edge, then settle 1 ns before anything is sampled or driven.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        t++;
        if (rst_cause == 2'b10) seen_wdt_cause = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        t = 0;
    endtask

    // Power-on sequence from a fresh release: 2 PRE cycles, 4 HOLD cycles, RUN.
    task automatic run_seq();
        int         p;
        logic [5:0] exp_v;
        logic [1:0] es;
        int         bad_d2 = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            p     = t % 10;
            es    = (t < 20) ? 2'b00 : (t < 60) ? 2'b01 : 2'b10;
            exp_v = {p == 9, p < 5, p == 5, !(t >= 20 && t < 60), es};
            check("seq", {26'd0, proc_ce, proc_clk, mem_phase, proc_resetn, state},
                  {26'd0, exp_v});
            if ({d2_ce, d2_mem, d2_clk} !== {t % 2 == 1, t % 2 == 1, t % 2 == 0}) bad_d2++;
        end
        check("div2_pattern_errors", bad_d2, 0);
    endtask

    initial begin
        int low_a, low_b;
        int resets_seen;

        // Reset values after 3 reset ticks.
        do_reset(3);
        check("rst_outs", {27'd0, proc_ce, proc_clk, mem_phase, proc_resetn, tie_zero},
              {27'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        check("rst_state", state, 2'b00);
        check("rst_cause", rst_cause, 2'b00);
        check("rst_d2", {d2_ce, d2_clk, d2_mem}, 3'b010);

        run_seq();
        check("run_cause_por", rst_cause, 2'b00);

        // External request in RUN (40 ticks low), then a re-request on the
        // third HOLD cycle (70 ticks low).
        low_a = 0;
        low_b = 0;
        while (t < 220) begin
            tick();
            if (!proc_resetn) begin
                if (t <= 130) low_a++;
                else          low_b++;
            end
            if (t == 80)  check("ext_run_enter_hold", state, 2'b01);
            if (t == 130) check("ext_run_cause", rst_cause, 2'b01);
            if (t == 209) check("rehold_still_hold", state, 2'b01);
            if (t == 210) check("rehold_run", state, 2'b10);
            ext_rst_req = (t == 78 || t == 79 || t == 138 || t == 139 ||
                           t == 168 || t == 169);
        end
        check("ext_run_low_ticks", low_a, 40);
        check("rehold_low_ticks", low_b, 70);

        // External request while still in PRE jumps straight to HOLD.
        do_reset(2);
        check("rst_clears_cause", rst_cause, 2'b00);
        while (t < 50) begin
            tick();
            if (t == 9)  check("pre_before_req", state, 2'b00);
            if (t == 10) check("pre_ext_hold", {proc_resetn, state, rst_cause}, 5'b0_01_01);
            if (t == 50) check("pre_ext_run", {proc_resetn, state, rst_cause}, 5'b1_10_01);
            ext_rst_req = (t == 8 || t == 9);
        end

        // Reset mid-HOLD aborts immediately and the sequence replays.
        do_reset(1);
        while (t < 30) tick();
        check("mid_hold_state", state, 2'b01);
        reset = 1'b1;
        tick();
        check("mid_hold_rst", {proc_ce, proc_clk, proc_resetn, state}, 5'b0_1_1_00);
        tick();
        tick();
        reset = 1'b0;
        t = 0;
        run_seq();

`ifdef PORF_WDT_EN
        // Watchdog with WDT_CYCLES=8: timeout 8 proc_ce after RUN, then
        // kicks every 5 processor cycles keep it in RUN.
        do_reset(2);
        while (t < 139) tick();
        check("wdt_pre_timeout", w_state, 2'b10);
        tick();
        check("wdt_timeout", {w_resetn, w_state, w_cause}, 5'b0_01_10);
        while (t < 180) tick();
        check("wdt_back_run", w_state, 2'b10);
        resets_seen = 0;
        for (int c = 1; c <= 100; c++) begin
            wdt_kick = (c % 5 == 0);
            repeat (10) begin
                tick();
                if (!w_resetn) resets_seen++;
            end
        end
        wdt_kick = 1'b0;
        check("wdt_kicked_no_reset", resets_seen, 0);
`else
        // Without the watchdog, kicks do nothing and RUN persists.
        resets_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            wdt_kick = (c % 2 == 0);
            tick();
            if (!proc_resetn) resets_seen++;
        end
        wdt_kick = 1'b0;
        check("kick_ignored", resets_seen, 0);
        check("never_wdt_cause", seen_wdt_cause, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
